// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line engine.
// Imported by the engine and its bench.
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REG_POS,
        ACTIVE,
        WAIT_POS,
        SPR_LINE,
        WAIT_DATA
    } state_t;

    localparam int SPR_COLRW = 4;
    typedef logic [SPR_COLRW-1:0] colr_t;

    // ROM read cycle plus output register
    localparam int SPR_LEAD = 2;

endpackage

// File: rtl/sprite_line_engine.sv
// One scalable hardware sprite, streamed from an external sync ROM per line.
// Optional SPRITE_TRANSPARENCY_EN masks drawing on TRANS_COLR pixels.
module sprite_line_engine
    import sprite_pkg::*;
#(
    parameter int CORDW      = 16,
    parameter int H_RES      = 640,
    parameter int SPR_W      = 8,
    parameter int SPR_H      = 8,
    parameter int SCALE_X    = 1,
    parameter int SCALE_Y    = 1,
    parameter int COLRW      = 4,
    parameter int ADDRW      = $clog2(SPR_W*SPR_H),
    parameter int TRANS_COLR = 0
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic signed [CORDW-1:0] sprx,
    input  logic signed [CORDW-1:0] spry,
    output logic [ADDRW-1:0]        rom_addr,
    input  logic [COLRW-1:0]        rom_data,
    output logic [COLRW-1:0]        pix,
    output logic                    drawing
);

    localparam int CXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
    localparam int CYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
    localparam int BXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int BYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [CXW-1:0] CX_MAX = CXW'(SCALE_X-1);
    localparam logic [CYW-1:0] CY_MAX = CYW'(SCALE_Y-1);
    localparam logic [BXW-1:0] BX_MAX = BXW'(SPR_W-1);

    localparam logic signed [CORDW:0] H_LAST = (CORDW+1)'(H_RES-1);
    localparam logic signed [CORDW:0] DY_LIM = (CORDW+1)'(SPR_H*SCALE_Y);
    localparam logic signed [CORDW:0] LEAD   = (CORDW+1)'(SPR_LEAD);

    state_t state, state_nx;

    logic signed [CORDW-1:0] sprx_q;
    logic signed [CORDW:0]   sx_e, dy, hit_x;
    logic [CXW-1:0]          cnt_x;
    logic [CYW-1:0]          cnt_y;
    logic [BXW-1:0]          bx;
    logic [BYW-1:0]          by;
    logic                    rom_vld;
    logic                    in_rng;
    logic                    wait_hit;
    logic                    last_px;
    logic                    opaque;

    assign sx_e     = {sx[CORDW-1], sx};
    assign dy       = {sy[CORDW-1], sy} - {spry[CORDW-1], spry};
    assign hit_x    = {sprx_q[CORDW-1], sprx_q} - LEAD;
    assign in_rng   = !dy[CORDW] && (dy < DY_LIM);
    assign wait_hit = (sx_e == hit_x);
    assign last_px  = (bx == BX_MAX) && (cnt_x == CX_MAX);

`ifdef SPRITE_TRANSPARENCY_EN
    assign opaque = (rom_data != COLRW'(TRANS_COLR));
`else
    assign opaque = 1'b1;
`endif

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      state_nx = IDLE;
            REG_POS:   state_nx = in_rng ? ACTIVE : IDLE;
            ACTIVE:    state_nx = WAIT_POS;
            WAIT_POS:  if (wait_hit) state_nx = SPR_LINE;
            SPR_LINE:  if (last_px) state_nx = WAIT_DATA;
            WAIT_DATA: state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (line) state_nx = REG_POS;
    end

    // by tracks dy/SCALE_Y across consecutive lines; dy==0 re-seeds it
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            sprx_q   <= '0;
            cnt_x    <= '0;
            cnt_y    <= '0;
            bx       <= '0;
            by       <= '0;
            rom_addr <= '0;
        end else begin
            unique case (state)
                REG_POS: begin
                    sprx_q <= sprx;
                    if (in_rng) begin
                        if (dy == '0) begin
                            cnt_y <= '0;
                            by    <= '0;
                        end else if (cnt_y == CY_MAX) begin
                            cnt_y <= '0;
                            by    <= by + 1'b1;
                        end else begin
                            cnt_y <= cnt_y + 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    rom_addr <= ADDRW'(int'(by) * SPR_W);
                    cnt_x    <= '0;
                    bx       <= '0;
                end
                SPR_LINE: begin
                    if (cnt_x == CX_MAX) begin
                        cnt_x <= '0;
                        if (!last_px) begin
                            bx       <= bx + 1'b1;
                            rom_addr <= rom_addr + 1'b1;
                        end
                    end else begin
                        cnt_x <= cnt_x + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A line pulse kills any pixel still in flight from the old line
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            rom_vld <= 1'b0;
            pix     <= '0;
            drawing <= 1'b0;
        end else begin
            rom_vld <= (state == SPR_LINE) && !line;
            pix     <= rom_vld ? rom_data : '0;
            drawing <= rom_vld && !line && (sx_e <= H_LAST) && opaque;
        end
    end

endmodule
